// File: rtl/lza_string_preencoder_if.sv
// Handshake bundle between the operand-alignment stage, the string pre-encoder
// and the LZA detection tree. The slave modport is the pre-encoder's view.
interface lza_string_preencoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a;
    logic [DATA_WIDTH-1:0] in_b;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] string_n;
    logic [DATA_WIDTH-1:0] string_z;
    logic [DATA_WIDTH-1:0] string_p;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  out_all_zero;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, string_n, string_z, string_p, out_tag, out_all_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, string_n, string_z, string_p, out_tag, out_all_zero
    );
endinterface

// File: rtl/lza_string_preencoder.sv
// Two-stage valid/ready pipeline producing the signed-digit indicator strings
// (n/z/p) of A - B for the LZA detection tree. S0 holds the operands, S1 the
// strings; full back-pressure with a combinational in_ready path from out_ready.
module lza_string_preencoder #(
    parameter int DATA_WIDTH = 8,
    parameter int TAG_WIDTH  = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    lza_string_preencoder_if.slave bus
);
    logic [DATA_WIDTH-1:0] s0_a_q, s0_b_q;
    logic [TAG_WIDTH-1:0]  s0_tag_q;
    logic                  s0_valid_q;

    logic [DATA_WIDTH-1:0] s1_n_q, s1_z_q, s1_p_q;
    logic [TAG_WIDTH-1:0]  s1_tag_q;
    logic                  s1_all_zero_q;
    logic                  s1_valid_q;

    logic [DATA_WIDTH-1:0] s1_n_d, s1_z_d, s1_p_d;
    logic                  s1_all_zero_d;
    logic                  s1_adv;
    logic                  s0_load;

    // Handshake: S1 advances when it is empty or being drained; S0 can take a
    // new pair when it is empty or its content moves into S1 this cycle.
    always_comb begin
        s1_adv       = s0_valid_q & (~s1_valid_q | bus.out_ready);
        bus.in_ready = ~s0_valid_q | s1_adv;
        s0_load      = bus.in_valid & bus.in_ready;
    end

    // Bitwise digit strings from the S0 operands; no carries involved.
    always_comb begin
        s1_n_d        = ~s0_a_q & s0_b_q;
        s1_z_d        = ~(s0_a_q ^ s0_b_q);
        s1_p_d        = s0_a_q & ~s0_b_q;
        s1_all_zero_d = &s1_z_d;
    end

    // Operand stage: load on accept, otherwise empty once drained into S1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_a_q     <= '0;
            s0_b_q     <= '0;
            s0_tag_q   <= '0;
            s0_valid_q <= 1'b0;
        end else if (s0_load) begin
            s0_a_q     <= bus.in_a;
            s0_b_q     <= bus.in_b;
            s0_tag_q   <= bus.in_tag;
            s0_valid_q <= 1'b1;
        end else if (s1_adv) begin
            s0_valid_q <= 1'b0;
        end
    end

    // String stage: load on advance, otherwise empty once the consumer takes it.
    // Data is held (not cleared) when emptied so outputs stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_n_q        <= '0;
            s1_z_q        <= '0;
            s1_p_q        <= '0;
            s1_tag_q      <= '0;
            s1_all_zero_q <= 1'b0;
            s1_valid_q    <= 1'b0;
        end else if (s1_adv) begin
            s1_n_q        <= s1_n_d;
            s1_z_q        <= s1_z_d;
            s1_p_q        <= s1_p_d;
            s1_tag_q      <= s0_tag_q;
            s1_all_zero_q <= s1_all_zero_d;
            s1_valid_q    <= 1'b1;
        end else if (bus.out_ready) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Outputs come straight from the S1 registers.
    always_comb begin
        bus.out_valid    = s1_valid_q;
        bus.string_n     = s1_n_q;
        bus.string_z     = s1_z_q;
        bus.string_p     = s1_p_q;
        bus.out_tag      = s1_tag_q;
        bus.out_all_zero = s1_all_zero_q;
    end
endmodule

// File: tb/tb_lza_string_preencoder.sv
// Scoreboard bench for lza_string_preencoder: expected strings are pushed on
// accept and compared on every output transfer.
module tb_lza_string_preencoder;
    localparam int DW = 8;
    localparam int TW = 4;

    logic clk;
    logic rst_n;

    lza_string_preencoder_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    lza_string_preencoder #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] n;
        logic [DW-1:0] z;
        logic [DW-1:0] p;
        logic [TW-1:0] tag;
        logic          az;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   lat_chk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; evaluates the handshake
    // for the coming rising edge, then returns at the following negedge.
    task automatic step(output bit acc);
        exp_t e;
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(bus.out_tag), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("string_n", 32'(bus.string_n), 32'(e.n));
                chk("string_z", 32'(bus.string_z), 32'(e.z));
                chk("string_p", 32'(bus.string_p), 32'(e.p));
                chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
                chk("all_zero", 32'(bus.out_all_zero), 32'(e.az));
                chk("onehot", 32'(((bus.string_n & bus.string_z) | (bus.string_n & bus.string_p) |
                                   (bus.string_z & bus.string_p)) == '0 &&
                                  (bus.string_n | bus.string_z | bus.string_p) == '1), 32'd1);
                if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
        if (acc) begin
            e.n   = ~bus.in_a & bus.in_b;
            e.z   = ~(bus.in_a ^ bus.in_b);
            e.p   = bus.in_a & ~bus.in_b;
            e.tag = bus.in_tag;
            e.az  = (bus.in_a == bus.in_b);
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [TW-1:0] t, input logic ordy);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = t;
        bus.out_ready = ordy;
    endtask

    initial begin
        bit acc;
        int n_acc;
        int sent;
        int guard;
        logic [DW-1:0] snap_n, snap_p;
        logic [TW-1:0] snap_tag;

        drive(0, '0, '0, '0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Test 1: reset with two pairs in flight.
        drive(1, 8'h11, 8'h22, 4'd1, 0); step(acc);
        drive(1, 8'h33, 8'h44, 4'd2, 0); step(acc);
        drive(0, '0, '0, '0, 0);
        #1;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_n", 32'(bus.string_n), 32'd0);
        chk("mid_rst_z", 32'(bus.string_z), 32'd0);
        chk("mid_rst_p", 32'(bus.string_p), 32'd0);
        chk("mid_rst_tag", 32'(bus.out_tag), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("no_stale_output", 32'(bus.out_valid), 32'd0);
            step(acc);
        end

        // Test 2: directed A5/5A.
        drive(1, 8'hA5, 8'h5A, 4'd3, 1); step(acc);
        drive(0, '0, '0, '0, 1); step(acc);
        #1;
        chk("t2_valid", 32'(bus.out_valid), 32'd1);
        chk("t2_n", 32'(bus.string_n), 32'h5A);
        chk("t2_z", 32'(bus.string_z), 32'h00);
        chk("t2_p", 32'(bus.string_p), 32'hA5);
        chk("t2_tag", 32'(bus.out_tag), 32'd3);
        chk("t2_az", 32'(bus.out_all_zero), 32'd0);
        step(acc);

        // Test 3: equal operands, then FF/00.
        drive(1, 8'h3C, 8'h3C, 4'd7, 1); step(acc);
        drive(1, 8'hFF, 8'h00, 4'd8, 1); step(acc);
        drive(0, '0, '0, '0, 1);
        #1;
        chk("t3_n", 32'(bus.string_n), 32'h00);
        chk("t3_z", 32'(bus.string_z), 32'hFF);
        chk("t3_p", 32'(bus.string_p), 32'h00);
        chk("t3_az", 32'(bus.out_all_zero), 32'd1);
        step(acc);
        #1;
        chk("t3_pff", 32'(bus.string_p), 32'hFF);
        chk("t3_az0", 32'(bus.out_all_zero), 32'd0);
        step(acc);
        step(acc);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Test 4: 16 back-to-back pairs, latency 2, one per cycle.
        lat_chk = 1;
        n_acc = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1, DW'($urandom), DW'($urandom), TW'(i), 1);
            step(acc);
            if (acc) n_acc++;
        end
        chk("t4_accepts", 32'(n_acc), 32'd16);
        drive(0, '0, '0, '0, 1);
        step(acc);
        step(acc);
        lat_chk = 0;
        chk("t4_drained", 32'(exp_q.size()), 32'd0);

        // Test 5: full stall holds exactly two pairs.
        n_acc = 0;
        drive(1, DW'($urandom), DW'($urandom), 4'd9, 0);
        for (int i = 0; i < 5; i++) begin
            step(acc);
            if (acc) begin
                n_acc++;
                drive(1, DW'($urandom), DW'($urandom), TW'(10 + i), 0);
            end
        end
        #1;
        snap_n = bus.string_n;
        snap_p = bus.string_p;
        snap_tag = bus.out_tag;
        step(acc);
        if (acc) n_acc++;
        #1;
        chk("t5_accepts", 32'(n_acc), 32'd2);
        chk("t5_in_ready", 32'(bus.in_ready), 32'd0);
        chk("t5_frozen_n", 32'(bus.string_n), 32'(snap_n));
        chk("t5_frozen_p", 32'(bus.string_p), 32'(snap_p));
        chk("t5_frozen_tag", 32'(bus.out_tag), 32'(snap_tag));
        drive(0, '0, '0, '0, 1);
        for (int i = 0; i < 4; i++) step(acc);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);

        // Test 6: random valid/ready, 1000 pairs.
        sent = 0;
        guard = 0;
        drive(0, '0, '0, '0, 0);
        acc = 1;
        while ((sent < 1000 || exp_q.size() != 0) && guard < 20000) begin
            if (!(bus.in_valid && !acc)) begin
                if (sent < 1000 && $urandom_range(1, 0) == 1)
                    drive(1, DW'($urandom), DW'($urandom), TW'($urandom), bus.out_ready);
                else
                    bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(1, 0) == 1);
            step(acc);
            if (acc) sent++;
            guard++;
        end
        chk("t6_timeout", 32'(guard < 20000), 32'd1);
        chk("t6_sent", 32'(sent), 32'd1000);
        chk("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
